// File: rtl/trace_if.sv
// trace_if: writeback debug bus into the recorder and the record stream out of it.
interface trace_if;
    logic [31:0] debug_wb_pc;
    logic        debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_addr;
    logic [31:0] debug_wb_rf_wdata;
    logic        rec_valid;
    logic        rec_ready;
    logic [71:0] rec_data;
    modport master(
        output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_addr, debug_wb_rf_wdata, rec_ready,
        input  rec_valid, rec_data
    );
    modport slave(
        input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_addr, debug_wb_rf_wdata, rec_ready,
        output rec_valid, rec_data
    );
endinterface

// File: rtl/trace_recorder.sv
// trace_recorder: captures register writebacks into a FIFO until FINAL_PC retires, then drains.
// Define TRACE_CHECKSUM_EN to enable the running record checksum; otherwise checksum is tied to 0.
module trace_recorder #(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] FINAL_PC = 32'h0000_003c
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    trace_if.slave      bus,
    output logic [31:0] rec_count,
    output logic [15:0] drop_count,
    output logic        overflow,
    output logic        done,
    output logic [31:0] checksum
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RECORD, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [71:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic cand, full, pop, push, drop;
    logic [71:0] rec;
    assign rec = {bus.debug_wb_pc, 3'b000, bus.debug_wb_rf_addr, bus.debug_wb_rf_wdata};
    assign full = count == (AW+1)'(DEPTH);
    assign cand = state == RECORD && bus.debug_wb_rf_wen && bus.debug_wb_rf_addr != 5'd0;
    assign pop = bus.rec_valid && bus.rec_ready;
    // a pop in the same cycle frees the slot a full FIFO needs
    assign push = cand && (!full || pop);
    assign drop = cand && full && !pop;
    assign bus.rec_valid = count != '0;
    assign bus.rec_data = bus.rec_valid ? mem[rd_ptr] : '0;
    assign done = state == DONE;
    always_comb begin
        state_n = state;
        if (state == IDLE && start) state_n = RECORD;
        if (state == RECORD && bus.debug_wb_pc == FINAL_PC) state_n = DRAIN;
        if (state == DRAIN && count == '0) state_n = DONE;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rec;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rec_count  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            count      <= count + (AW+1)'(push) - (AW+1)'(pop);
            rec_count  <= rec_count + 32'(push && rec_count != '1);
            drop_count <= drop_count + 16'(drop && drop_count != '1);
            overflow   <= overflow | drop;
        end
    end
`ifdef TRACE_CHECKSUM_EN
    logic [31:0] csum;
    always_ff @(posedge clk) begin
        if (reset) csum <= '0;
        else if (push) csum <= {csum[30:0], csum[31]} ^ bus.debug_wb_pc ^ {27'b0, bus.debug_wb_rf_addr} ^ bus.debug_wb_rf_wdata;
    end
    assign checksum = csum;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_trace_recorder.sv
// tb_trace_recorder: directed stimulus with a scoreboard queue checked by an independent record monitor.
module tb_trace_recorder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [31:0] rec_count, checksum;
    logic [15:0] drop_count;
    logic overflow, done;
    int checks = 0;
    int errors = 0;
    logic [71:0] q[$];
    trace_if bus();
    trace_recorder dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .rec_count(rec_count), .drop_count(drop_count), .overflow(overflow),
        .done(done), .checksum(checksum)
    );
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] r(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        return {pc, 3'b000, a, d};
    endfunction

    function automatic logic [31:0] cs_next(input logic [31:0] cs, input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        return {cs[30:0], cs[31]} ^ pc ^ {27'b0, a} ^ d;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic wen, input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.debug_wb_pc = pc;
        bus.debug_wb_rf_wen = wen;
        bus.debug_wb_rf_addr = a;
        bus.debug_wb_rf_wdata = d;
    endtask

    task automatic idle();
        drive(32'h1000, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b0;
        bus.rec_ready = 1'b0;
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 72'(bus.rec_valid), 72'd0);
        chk({tag, "_data"}, bus.rec_data, 72'd0);
        chk({tag, "_rec_count"}, 72'(rec_count), 72'd0);
        chk({tag, "_drop_count"}, 72'(drop_count), 72'd0);
        chk({tag, "_overflow"}, 72'(overflow), 72'd0);
        chk({tag, "_done"}, 72'(done), 72'd0);
        chk({tag, "_checksum"}, 72'(checksum), 72'd0);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 100 && bus.rec_valid; i++) @(negedge clk);
        chk({tag, "_drain_timeout"}, 72'(bus.rec_valid), 72'd0);
        chk({tag, "_sb_empty"}, 72'(q.size()), 72'd0);
    endtask

    initial begin
        logic pv;
        logic [71:0] pd;
        pv = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (reset) pv = 1'b0;
            else begin
                if (pv) begin
                    chk("stall_valid", 72'(bus.rec_valid), 72'd1);
                    chk("stall_data", bus.rec_data, pd);
                end
                if (bus.rec_valid && bus.rec_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rec: got %h required no record", bus.rec_data);
                    end else chk("rec_data", bus.rec_data, q.pop_front());
                end
                pv = bus.rec_valid && !bus.rec_ready;
                pd = bus.rec_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_cs;
        bus.debug_wb_pc = 32'h1000;
        bus.debug_wb_rf_wen = 1'b0;
        bus.debug_wb_rf_addr = 5'd0;
        bus.debug_wb_rf_wdata = 32'h0;
        bus.rec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_zero("reset");
        // candidate presented in the start cycle must not be captured
        @(posedge clk); #1;
        start = 1'b1;
        bus.debug_wb_pc = 32'h100;
        bus.debug_wb_rf_wen = 1'b1;
        bus.debug_wb_rf_addr = 5'd7;
        bus.debug_wb_rf_wdata = 32'h77;
        @(posedge clk); #1;
        start = 1'b0;
        bus.debug_wb_rf_wen = 1'b0;
        @(negedge clk);
        chk("start_cycle_count", 72'(rec_count), 72'd0);
        chk("start_cycle_valid", 72'(bus.rec_valid), 72'd0);
        // first record, presented one cycle later and not popped in its push cycle
        bus.rec_ready = 1'b1;
        q.push_back(72'h00000004_05_00001234);
        drive(32'h4, 1'b1, 5'd5, 32'h1234);
        idle();
        @(negedge clk);
        chk("first_valid", 72'(bus.rec_valid), 72'd1);
        chk("first_count", 72'(rec_count), 72'd1);
        // filtered candidates
        drive(32'h8, 1'b1, 5'd0, 32'hBAD);
        drive(32'hC, 1'b0, 5'd3, 32'hBAD);
        idle();
        repeat (2) @(negedge clk);
        chk("filtered_count", 72'(rec_count), 72'd1);
        chk("filtered_valid", 72'(bus.rec_valid), 72'd0);
        // overflow with a stalled consumer
        do_reset();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) q.push_back(r(32'h100 + 32'(4 * i), 5'(i % 31 + 1), 32'hA000 + 32'(i)));
            drive(32'h100 + 32'(4 * i), 1'b1, 5'(i % 31 + 1), 32'hA000 + 32'(i));
        end
        idle();
        @(negedge clk);
        chk("ovf_rec_count", 72'(rec_count), 72'd16);
        chk("ovf_drop_count", 72'(drop_count), 72'd4);
        chk("ovf_overflow", 72'(overflow), 72'd1);
        chk("ovf_valid", 72'(bus.rec_valid), 72'd1);
        repeat (3) @(posedge clk);
        // full FIFO, pop and candidate in the same cycle
        q.push_back(r(32'h200, 5'd9, 32'h5555));
        drive(32'h200, 1'b1, 5'd9, 32'h5555);
        bus.rec_ready = 1'b1;
        idle();
        @(negedge clk);
        chk("fullpop_drop_count", 72'(drop_count), 72'd4);
        chk("fullpop_rec_count", 72'(rec_count), 72'd17);
        wait_empty("ovf");
        // final PC ends the run
        do_reset();
        pulse_start();
        q.push_back(r(32'h10, 5'd1, 32'h11));
        drive(32'h10, 1'b1, 5'd1, 32'h11);
        q.push_back(r(32'h14, 5'd3, 32'h33));
        drive(32'h14, 1'b1, 5'd3, 32'h33);
        q.push_back(r(32'h18, 5'd4, 32'h44));
        drive(32'h18, 1'b1, 5'd4, 32'h44);
        q.push_back(r(32'h3c, 5'd2, 32'hDEAD));
        drive(32'h3c, 1'b1, 5'd2, 32'hDEAD);
        drive(32'h50, 1'b1, 5'd6, 32'h66);
        idle();
        @(negedge clk);
        chk("final_rec_count", 72'(rec_count), 72'd4);
        chk("final_done_busy", 72'(done), 72'd0);
        @(posedge clk); #1 bus.rec_ready = 1'b1;
        wait_empty("final");
        chk("done_on_empty", 72'(done), 72'd0);
        @(negedge clk);
        chk("done_after_empty", 72'(done), 72'd1);
        drive(32'h60, 1'b1, 5'd7, 32'h77);
        start = 1'b1;
        idle();
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_ignore_count", 72'(rec_count), 72'd4);
        chk("done_hold", 72'(done), 72'd1);
        chk("done_valid", 72'(bus.rec_valid), 72'd0);
        // checksum, then reset while draining
        do_reset();
        pulse_start();
        q.push_back(r(32'h4, 5'd1, 32'h1));
        drive(32'h4, 1'b1, 5'd1, 32'h1);
        q.push_back(r(32'h8, 5'd2, 32'h2));
        drive(32'h8, 1'b1, 5'd2, 32'h2);
        drive(32'h3c, 1'b0, 5'd0, 32'h0);
        idle();
        @(negedge clk);
`ifdef TRACE_CHECKSUM_EN
        exp_cs = cs_next(cs_next(32'h0, 32'h4, 5'd1, 32'h1), 32'h8, 5'd2, 32'h2);
`else
        exp_cs = 32'h0;
`endif
        chk("cs_rec_count", 72'(rec_count), 72'd2);
        chk("cs_value", 72'(checksum), 72'(exp_cs));
        chk("drain_valid", 72'(bus.rec_valid), 72'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        q.delete();
        @(posedge clk); #1 reset = 1'b0;
        check_zero("drain_reset");
        drive(32'h20, 1'b1, 5'd3, 32'h33);
        idle();
        @(negedge clk);
        chk("idle_no_capture", 72'(rec_count), 72'd0);
        pulse_start();
        bus.rec_ready = 1'b1;
        q.push_back(r(32'h24, 5'd3, 32'h99));
        drive(32'h24, 1'b1, 5'd3, 32'h99);
        idle();
        @(negedge clk);
        wait_empty("restart");
        chk("restart_count", 72'(rec_count), 72'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
